// File: rtl/mem_stage.sv
// Memory stage: forwards ALU results to writeback and runs single-outstanding
// load/store transactions on the data bus with an ack timeout.
module mem_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] instr_in,
  input  logic [15:0] res_in,
  input  logic [15:0] addr_in,
  input  logic [3:0]  dest_in,
  input  logic        t_written_in,
  input  logic        t_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_en,
  output logic [3:0]  wb_dest,
  output logic [15:0] wb_data,
  output logic        t_reg,
  output logic        stall,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } state_t;

  // The counter holds the number of ack-less cycles already spent, so the
  // last permitted wait cycle is the one where it equals TIMEOUT-1.
  localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_nextState;
  logic        r_memReq;
  logic        r_memWe;
  logic [15:0] r_memAddr;
  logic [15:0] r_memWdata;
  logic        r_wbEn;
  logic [3:0]  r_wbDest;
  logic [15:0] r_wbData;
  logic [3:0]  r_dest;
  logic [3:0]  r_count;
  logic        r_tReg;
  logic        r_memErr;

  logic        w_isLoad;
  logic        w_isStore;
  logic        w_start;
  logic        w_done;
  logic        w_abort;
  logic        w_unusedBits;

  assign w_isLoad     = (instr_in[15:11] == 5'b10010) || (instr_in[15:11] == 5'b10011);
  assign w_isStore    = (instr_in[15:11] == 5'b11010) || (instr_in[15:11] == 5'b11011);
  assign w_unusedBits = ^instr_in[10:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (valid_in && (w_isLoad || w_isStore)) begin
          w_start     = 1'b1;
          w_nextState = w_isLoad ? LOAD : STORE;
        end
      end
      LOAD, STORE: begin
        // An ack in the final wait cycle still wins over the timeout.
        if (mem_ack) begin
          w_done      = 1'b1;
          w_nextState = IDLE;
        end else if (r_count == LAST_WAIT) begin
          w_abort     = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= 16'h0000;
      r_memWdata <= 16'h0000;
      r_wbEn     <= 1'b0;
      r_wbDest   <= 4'h0;
      r_wbData   <= 16'h0000;
      r_dest     <= 4'h0;
      r_count    <= 4'h0;
      r_tReg     <= 1'b0;
      r_memErr   <= 1'b0;
    end else begin
      r_wbEn <= 1'b0;
      if (r_state == IDLE) begin
        if (valid_in) begin
          if (!t_written_in) begin
            r_tReg <= t_in;
          end
          if (w_isLoad) begin
            r_memReq  <= 1'b1;
            r_memWe   <= 1'b0;
            r_memAddr <= addr_in;
            r_dest    <= dest_in;
            r_count   <= 4'h0;
          end else if (w_isStore) begin
            r_memReq   <= 1'b1;
            r_memWe    <= 1'b1;
            r_memAddr  <= addr_in;
            r_memWdata <= res_in;
            r_count    <= 4'h0;
          end else begin
            r_wbEn   <= (dest_in != 4'hF);
            r_wbDest <= dest_in;
            r_wbData <= res_in;
          end
        end
      end else if (w_done || w_abort) begin
        r_memReq <= 1'b0;
        r_memWe  <= 1'b0;
        r_count  <= 4'h0;
        if (w_done && (r_state == LOAD)) begin
          r_wbEn   <= 1'b1;
          r_wbDest <= r_dest;
          r_wbData <= mem_rdata;
        end
        if (w_abort) begin
          r_memErr <= 1'b1;
        end
      end else begin
        r_count <= r_count + 4'd1;
      end
    end
  end

  // Stall must rise in the same cycle a memory op is offered, before any edge.
  assign stall     = rst & ((r_state != IDLE) | w_start);
  assign mem_req   = r_memReq;
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign wb_en     = r_wbEn;
  assign wb_dest   = r_wbDest;
  assign wb_data   = r_wbData;
  assign t_reg     = r_tReg;
  assign mem_err   = r_memErr;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: scenario tasks with inline checks, plus a writeback
// scoreboard that pops an expected {dest,data} on every wb_en pulse.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [15:0] instr_in = 16'h0;
  logic [15:0] res_in = 16'h0;
  logic [15:0] addr_in = 16'h0;
  logic [3:0]  dest_in = 4'hF;
  logic        t_written_in = 1'b1;
  logic        t_in = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_ack = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [15:0] wb_data;
  logic        t_reg;
  logic        stall;
  logic        mem_err;

  typedef struct packed {
    logic [3:0]  dest;
    logic [15:0] data;
  } wb_t;

  wb_t expQ[$];
  int  nChecks = 0;
  int  nFails = 0;

  localparam logic [15:0] OP_ADDU = 16'h0123;
  localparam logic [15:0] OP_CMP  = 16'h2800;
  localparam logic [15:0] OP_LW   = 16'h9000;
  localparam logic [15:0] OP_LWSP = 16'h9800;
  localparam logic [15:0] OP_SW   = 16'hD000;
  localparam logic [15:0] OP_SWSP = 16'hD800;

  mem_stage #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .instr_in(instr_in),
    .res_in(res_in), .addr_in(addr_in), .dest_in(dest_in),
    .t_written_in(t_written_in), .t_in(t_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .t_reg(t_reg), .stall(stall), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Every writeback pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    wb_t e;
    if (rst && wb_en) begin
      nChecks++;
      if (expQ.size() == 0) begin
        nFails++;
        $display("[TB] FAIL wb_unexpected: got dest=%0d data=%h, required no writeback", wb_dest, wb_data);
      end else begin
        e = expQ.pop_front();
        if ({wb_dest, wb_data} !== e) begin
          nFails++;
          $display("[TB] FAIL wb_scoreboard: got dest=%0d data=%h, required dest=%0d data=%h",
                   wb_dest, wb_data, e.dest, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [15:0] instr, input logic [15:0] res, input logic [15:0] addr,
                         input logic [3:0] dest, input logic tw, input logic tv);
    valid_in = 1'b1; instr_in = instr; res_in = res; addr_in = addr;
    dest_in = dest; t_written_in = tw; t_in = tv;
  endtask

  task automatic idleIn();
    valid_in = 1'b0; instr_in = 16'h0; res_in = 16'h0; addr_in = 16'h0;
    dest_in = 4'hF; t_written_in = 1'b1; t_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    present(OP_LW, 16'h1111, 16'h2222, 4'd4, 1'b0, 1'b1);
    mem_ack = 1'b1;
    #3;
    nChecks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== 34'h0) begin
      nFails++;
      $display("[TB] FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h, required all 0", mem_req, mem_we, mem_addr, mem_wdata);
    end
    nChecks++;
    if ({wb_en, wb_dest, wb_data} !== 21'h0) begin
      nFails++;
      $display("[TB] FAIL reset_wb: got en=%b dest=%h data=%h, required all 0", wb_en, wb_dest, wb_data);
    end
    nChecks++;
    if ({t_reg, stall, mem_err} !== 3'b000) begin
      nFails++;
      $display("[TB] FAIL reset_flags: got t=%b stall=%b err=%b, required 000", t_reg, stall, mem_err);
    end
    mem_ack = 1'b0;
    idleIn();
    @(negedge clk);
    rst = 1'b1;
    present(OP_ADDU, 16'h00A1, 16'h0, 4'd1, 1'b1, 1'b0);
    expQ.push_back({4'd1, 16'h00A1});
    tick();
    idleIn();
    nChecks++;
    if (wb_en !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL first_op_after_reset: got wb_en=%b, required 1", wb_en);
    end
  endtask

  task automatic test_alu();
    present(OP_ADDU, 16'h1234, 16'h0, 4'd3, 1'b1, 1'b0);
    expQ.push_back({4'd3, 16'h1234});
    #1;
    nChecks++;
    if (stall !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL alu_stall: got %b, required 0", stall);
    end
    tick();
    nChecks++;
    if ({wb_en, wb_dest, wb_data} !== {1'b1, 4'd3, 16'h1234}) begin
      nFails++;
      $display("[TB] FAIL alu_wb: got en=%b dest=%0d data=%h, required 1/3/1234", wb_en, wb_dest, wb_data);
    end
    present(OP_ADDU, 16'h5555, 16'h0, 4'hF, 1'b1, 1'b0);
    tick();
    nChecks++;
    if (wb_en !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL alu_nodest: got wb_en=%b, required 0", wb_en);
    end
    idleIn();
    tick();
    nChecks++;
    if (wb_en !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL idle_wb: got wb_en=%b, required 0", wb_en);
    end
  endtask

  task automatic test_load();
    present(OP_LW, 16'h7777, 16'h8000, 4'd5, 1'b1, 1'b0);
    #1;
    nChecks++;
    if ({stall, mem_req} !== 2'b10) begin
      nFails++;
      $display("[TB] FAIL load_present: got stall=%b req=%b, required stall=1 req=0", stall, mem_req);
    end
    tick();
    // Upstream keeps offering an op while frozen; it must be ignored.
    present(OP_ADDU, 16'h3333, 16'h0, 4'd6, 1'b1, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      nChecks++;
      if ({mem_req, mem_we, mem_addr, stall} !== {1'b1, 1'b0, 16'h8000, 1'b1}) begin
        nFails++;
        $display("[TB] FAIL load_wait c%0d: got req=%b we=%b addr=%h stall=%b, required 1/0/8000/1", c, mem_req, mem_we, mem_addr, stall);
      end
      if (c == 3) begin
        mem_ack = 1'b1;
        mem_rdata = 16'hBEEF;
        expQ.push_back({4'd5, 16'hBEEF});
      end else begin
        mem_rdata = 16'hDEAD;
      end
      tick();
    end
    mem_ack = 1'b0;
    idleIn();
    #1;
    nChecks++;
    if ({mem_req, stall, wb_en, wb_dest, wb_data} !== {1'b0, 1'b0, 1'b1, 4'd5, 16'hBEEF}) begin
      nFails++;
      $display("[TB] FAIL load_done: got req=%b stall=%b en=%b dest=%0d data=%h, required 0/0/1/5/BEEF", mem_req, stall, wb_en, wb_dest, wb_data);
    end
    tick();
    nChecks++;
    if (wb_en !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL load_single_pulse: got wb_en=%b, required 0", wb_en);
    end
  endtask

  task automatic test_store();
    present(OP_SW, 16'hA5A5, 16'h0010, 4'd7, 1'b1, 1'b0);
    tick();
    idleIn();
    nChecks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, stall} !== {1'b1, 1'b1, 16'h0010, 16'hA5A5, 1'b1}) begin
      nFails++;
      $display("[TB] FAIL store_bus: got req=%b we=%b addr=%h wdata=%h stall=%b, required 1/1/0010/A5A5/1", mem_req, mem_we, mem_addr, mem_wdata, stall);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1;
    nChecks++;
    if ({mem_req, stall, wb_en} !== 3'b000) begin
      nFails++;
      $display("[TB] FAIL store_done: got req=%b stall=%b wb_en=%b, required 000", mem_req, stall, wb_en);
    end
  endtask

  task automatic test_tflag();
    present(OP_CMP, 16'h0000, 16'h0, 4'hF, 1'b0, 1'b1);
    tick();
    nChecks++;
    if (t_reg !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL tflag_set: got %b, required 1", t_reg);
    end
    present(OP_ADDU, 16'h0001, 16'h0, 4'hF, 1'b1, 1'b0);
    tick();
    nChecks++;
    if (t_reg !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL tflag_hold: got %b, required 1", t_reg);
    end
    present(OP_LWSP, 16'h0000, 16'h0040, 4'd8, 1'b0, 1'b0);
    tick();
    nChecks++;
    if (t_reg !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL tflag_load: got %b, required 0", t_reg);
    end
    present(OP_CMP, 16'h0000, 16'h0, 4'hF, 1'b0, 1'b1);
    mem_ack = 1'b1;
    mem_rdata = 16'h0F0F;
    expQ.push_back({4'd8, 16'h0F0F});
    tick();
    mem_ack = 1'b0;
    idleIn();
    nChecks++;
    if (t_reg !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL tflag_frozen: got %b, required 0", t_reg);
    end
  endtask

  task automatic test_ack_at_limit();
    present(OP_LW, 16'h0, 16'h0100, 4'd10, 1'b1, 1'b0);
    tick();
    idleIn();
    for (int c = 1; c <= 15; c++) begin
      if (c == 15) begin
        mem_ack = 1'b1;
        mem_rdata = 16'h5A5A;
        expQ.push_back({4'd10, 16'h5A5A});
      end
      tick();
    end
    mem_ack = 1'b0;
    #1;
    nChecks++;
    if ({mem_req, mem_err, stall, wb_en} !== 4'b0001) begin
      nFails++;
      $display("[TB] FAIL ack_at_limit: got req=%b err=%b stall=%b wb_en=%b, required 0/0/0/1", mem_req, mem_err, stall, wb_en);
    end
  endtask

  task automatic test_back_to_back();
    present(OP_SWSP, 16'hC0DE, 16'h0200, 4'd0, 1'b1, 1'b0);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    present(OP_LW, 16'h0, 16'h0300, 4'd11, 1'b1, 1'b0);
    #1;
    nChecks++;
    if (stall !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL b2b_stall: got %b, required 1", stall);
    end
    tick();
    nChecks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0300}) begin
      nFails++;
      $display("[TB] FAIL b2b_load_bus: got req=%b we=%b addr=%h, required 1/0/0300", mem_req, mem_we, mem_addr);
    end
    mem_ack = 1'b1;
    mem_rdata = 16'h1357;
    expQ.push_back({4'd11, 16'h1357});
    idleIn();
    tick();
    present(OP_ADDU, 16'h2468, 16'h0, 4'd12, 1'b1, 1'b0);
    mem_rdata = 16'hFFFF;
    expQ.push_back({4'd12, 16'h2468});
    tick();
    mem_ack = 1'b0;
    idleIn();
    #1;
    nChecks++;
    if ({mem_req, stall, wb_data} !== {1'b0, 1'b0, 16'h2468}) begin
      nFails++;
      $display("[TB] FAIL spurious_ack: got req=%b stall=%b data=%h, required 0/0/2468", mem_req, stall, wb_data);
    end
    tick();
  endtask

  task automatic test_timeout();
    present(OP_LWSP, 16'h0, 16'h1234, 4'd9, 1'b1, 1'b0);
    tick();
    idleIn();
    for (int c = 1; c <= 15; c++) begin
      nChecks++;
      if ({mem_req, mem_err} !== 2'b10) begin
        nFails++;
        $display("[TB] FAIL timeout_wait c%0d: got req=%b err=%b, required 1/0", c, mem_req, mem_err);
      end
      tick();
    end
    nChecks++;
    if ({mem_req, stall, mem_err, wb_en} !== 4'b0010) begin
      nFails++;
      $display("[TB] FAIL timeout_abort: got req=%b stall=%b err=%b wb_en=%b, required 0/0/1/0", mem_req, stall, mem_err, wb_en);
    end
    present(OP_ADDU, 16'h0042, 16'h0, 4'd2, 1'b1, 1'b0);
    expQ.push_back({4'd2, 16'h0042});
    tick();
    idleIn();
    nChecks++;
    if (wb_en !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL timeout_next_op: got wb_en=%b, required 1", wb_en);
    end
    tick();
    tick();
    nChecks++;
    if (mem_err !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL err_sticky: got %b, required 1", mem_err);
    end
  endtask

  task automatic test_reset_mid_load();
    present(OP_LW, 16'h0, 16'h4444, 4'd13, 1'b1, 1'b0);
    tick();
    idleIn();
    tick();
    #2;
    rst = 1'b0;
    #1;
    nChecks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== 34'h0) begin
      nFails++;
      $display("[TB] FAIL midreset_bus: got req=%b we=%b addr=%h wdata=%h, required all 0", mem_req, mem_we, mem_addr, mem_wdata);
    end
    nChecks++;
    if ({wb_en, wb_dest, wb_data, t_reg, stall, mem_err} !== 24'h0) begin
      nFails++;
      $display("[TB] FAIL midreset_out: got en=%b dest=%h data=%h t=%b stall=%b err=%b, required all 0", wb_en, wb_dest, wb_data, t_reg, stall, mem_err);
    end
    mem_rdata = 16'h9999;
    mem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    tick();
    mem_ack = 1'b0;
    nChecks++;
    if ({mem_req, stall} !== 2'b00) begin
      nFails++;
      $display("[TB] FAIL midreset_release: got req=%b stall=%b, required 00", mem_req, stall);
    end
    repeat (3) tick();
    nChecks++;
    if (wb_en !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL midreset_no_wb: got wb_en=%b, required 0", wb_en);
    end
  endtask

  initial begin
    $display("[TB] mem_stage bench starting");
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_tflag();
    test_ack_at_limit();
    test_back_to_back();
    test_timeout();
    test_reset_mid_load();
    nChecks++;
    if (expQ.size() != 0) begin
      nFails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending writebacks, required 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles to wait for mem_ack before abort.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port valid_in, input, 1 bit: execute-stage result valid this cycle.
REQ-005 SHALL have port instr_in, input, 16 bits: instruction word of the executing op.
REQ-006 SHALL have port res_in, input, 16 bits: execute result, which is the store data for sw/sw_sp.
REQ-007 SHALL have port addr_in, input, 16 bits: effective memory address for lw/lw_sp/sw/sw_sp.
REQ-008 SHALL have port dest_in, input, 4 bits: writeback register index, where 4'hF means no writeback.
REQ-009 SHALL have ports t_written_in and t_in, input, 1 bit each: t_written_in=0 means update T with t_in.
REQ-010 SHALL have ports mem_req, mem_we (output, 1 bit each), mem_addr, mem_wdata (output, 16 bits each), mem_rdata (input, 16 bits) and mem_ack (input, 1 bit): data-memory bus.
REQ-011 SHALL have ports wb_en (output, 1 bit), wb_dest (output, 4 bits) and wb_data (output, 16 bits): register-file writeback.
REQ-012 SHALL have port t_reg, output, 1 bit: architectural T flag.
REQ-013 SHALL have port stall, output, 1 bit: freeze upstream stages.
REQ-014 SHALL have port mem_err, output, 1 bit: sticky bus-timeout flag.

Function
REQ-015 SHALL decode instr_in[15:11] as follows: 10010/10011 is a load; 11010/11011 is a store; all other values are non-memory.
REQ-016 SHALL implement FSM states IDLE, LOAD, STORE.
REQ-017 SHALL, in IDLE with valid_in=1 and a non-memory op, register wb_en=(dest_in!=4'hF), wb_dest=dest_in and wb_data=res_in on the next edge (1-cycle latency), and SHALL keep stall=0.
REQ-018 SHALL, in IDLE with valid_in=1 and a load, capture addr_in/dest_in, drive mem_req=1 and mem_we=0, assert stall, and go to LOAD.
REQ-019 SHALL, in IDLE with valid_in=1 and a store, capture addr_in/res_in, drive mem_req=1 and mem_we=1, assert stall, and go to STORE.
REQ-020 SHALL assert stall combinationally in the cycle a memory op is presented in IDLE, and SHALL hold it while in LOAD/STORE.
REQ-021 SHALL, in LOAD on mem_ack=1, pulse wb_en=1 for one cycle with wb_data=mem_rdata and the captured dest, deassert mem_req and stall, and return to IDLE.
REQ-022 SHALL, in STORE on mem_ack=1, deassert mem_req and stall, return to IDLE, and produce no writeback.
REQ-023 SHALL hold mem_addr, mem_wdata and mem_we stable while mem_req=1.
REQ-024 SHALL count cycles in LOAD/STORE with a 4-bit counter; when the count reaches TIMEOUT without ack, it SHALL drop mem_req and stall, set mem_err=1, return to IDLE, and produce no writeback.
REQ-025 SHALL clear mem_err only by reset.
REQ-026 SHALL ignore valid_in while in LOAD/STORE, since upstream is frozen.
REQ-027 SHALL update t_reg<=t_in on the edge where valid_in=1 and t_written_in=0, in IDLE only, for any op class.
REQ-028 SHALL drive wb_en=0 in every cycle not specified above, including valid_in=0.
REQ-029 SHALL accept an ack arriving in the same cycle as the counter reaching TIMEOUT, and SHALL not set mem_err in that case.
REQ-030 SHALL treat mem_ack seen in IDLE as spurious and ignore it.

Reset
REQ-031 SHALL, on rst=0 at any time including mid-transaction, asynchronously force state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_en=0, wb_dest=0, wb_data=0, t_reg=0, stall=0, mem_err=0, counter=0.
REQ-032 SHALL, after rst deasserts, accept the first op on the next rising edge.

Verification
REQ-033 SHALL pass this scenario: addu with res_in=16'h1234 and dest_in=3 -> next cycle wb_en=1, wb_dest=3, wb_data=16'h1234, stall=0.
REQ-034 SHALL pass this scenario: lw with addr_in=16'h8000, dest_in=5, ack after 3 cycles with mem_rdata=16'hBEEF -> mem_req high for 3 cycles, stall high throughout, then a single wb_en pulse with wb_data=16'hBEEF and wb_dest=5.
REQ-035 SHALL pass this scenario: sw with addr_in=16'h0010, res_in=16'hA5A5, ack after 1 cycle -> mem_we=1, mem_wdata=16'hA5A5, no wb_en, stall released the cycle after ack.
REQ-036 SHALL pass this scenario: lw with no ack -> after 15 cycles mem_req=0, stall=0, mem_err=1 (sticky), no writeback; a following addu completes normally.
REQ-037 SHALL pass this scenario: cmp with t_written_in=0 and t_in=1 -> t_reg=1; a following op with t_written_in=1 and t_in=0 -> t_reg stays 1.
REQ-038 SHALL pass this scenario: rst pulled low during LOAD -> all outputs zero immediately; no writeback after release.
